// File: rtl/bexkat1_ifetch.sv
// bexkat1 instruction fetch stage.
// Fetches 32-bit words over a Wishbone-classic port and assembles the 64-bit IR
// (a set bit 0 in word0 marks a long instruction whose immediate follows in word1).
// Honours the hazard-unit stall and redirects from EXE.
// Optional feature: define BEXKAT1_IFETCH_COUNT_EN to add fetch_count_o, a running
// count of instructions delivered to ID.
module bexkat1_ifetch #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        pc_set_i,
    input  logic [31:0] pc_i,
    output logic        bus_cyc_o,
    output logic        bus_stb_o,
    output logic [31:0] bus_adr_o,
    input  logic [31:0] bus_dat_i,
    input  logic        bus_ack_i,
    output logic [63:0] ir_o,
    output logic [31:0] pc_o
`ifdef BEXKAT1_IFETCH_COUNT_EN
    ,
    output logic [31:0] fetch_count_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_W0   = 2'd1,
        S_W1   = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t      state, next_state;
    logic [31:0] fetch_pc, fetch_pc_next;
    logic [31:0] word0, word0_next;
    logic [63:0] ir_q, ir_next;
    logic [31:0] pc_q, pc_next;
    logic [63:0] pend_ir, pend_ir_next;
    logic [31:0] pend_pc, pend_pc_next;
    logic        load_ir;
    logic        complete;
    logic [63:0] complete_ir;
    logic [31:0] pc_advance;

    // The bus is only active while a word is being fetched; word1 sits right after word0.
    always_comb begin
        bus_cyc_o = (state == S_W0) || (state == S_W1);
        bus_stb_o = bus_cyc_o;
        bus_adr_o = (state == S_W1) ? fetch_pc + 32'd4 : fetch_pc;
    end

    assign ir_o = ir_q;
    assign pc_o = pc_q;

    // Next-state logic: instruction assembly, delivery to ID, stall parking and redirect.
    always_comb begin
        next_state    = state;
        fetch_pc_next = fetch_pc;
        word0_next    = word0;
        ir_next       = stall_i ? ir_q : 64'h0;
        pc_next       = stall_i ? pc_q : 32'h0;
        pend_ir_next  = pend_ir;
        pend_pc_next  = pend_pc;
        load_ir       = 1'b0;
        complete      = 1'b0;
        complete_ir   = 64'h0;
        pc_advance    = 32'd0;

        case (state)
            S_IDLE: next_state = S_W0;
            S_W0: begin
                if (bus_ack_i) begin
                    word0_next = bus_dat_i;
                    if (bus_dat_i[0]) begin
                        next_state = S_W1;
                    end else begin
                        complete    = 1'b1;
                        complete_ir = {32'h0, bus_dat_i};
                        pc_advance  = 32'd4;
                    end
                end
            end
            S_W1: begin
                if (bus_ack_i) begin
                    complete    = 1'b1;
                    complete_ir = {bus_dat_i, word0};
                    pc_advance  = 32'd8;
                end
            end
            S_HOLD: begin
                if (!stall_i) begin
                    ir_next    = pend_ir;
                    pc_next    = pend_pc;
                    load_ir    = 1'b1;
                    next_state = S_W0;
                end
            end
            default: next_state = S_IDLE;
        endcase

        if (complete) begin
            fetch_pc_next = fetch_pc + pc_advance;
            if (!stall_i) begin
                ir_next    = complete_ir;
                pc_next    = fetch_pc;
                load_ir    = 1'b1;
                next_state = S_W0;
            end else begin
                pend_ir_next = complete_ir;
                pend_pc_next = fetch_pc;
                next_state   = S_HOLD;
            end
        end

        if (pc_set_i) begin
            fetch_pc_next = pc_i & 32'hFFFF_FFFC;
            ir_next       = 64'h0;
            pc_next       = 32'h0;
            pend_ir_next  = 64'h0;
            pend_pc_next  = 32'h0;
            load_ir       = 1'b0;
            next_state    = S_IDLE;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state    <= S_IDLE;
            fetch_pc <= RESET_VEC;
            word0    <= 32'h0;
            ir_q     <= 64'h0;
            pc_q     <= 32'h0;
            pend_ir  <= 64'h0;
            pend_pc  <= 32'h0;
        end else begin
            state    <= next_state;
            fetch_pc <= fetch_pc_next;
            word0    <= word0_next;
            ir_q     <= ir_next;
            pc_q     <= pc_next;
            pend_ir  <= pend_ir_next;
            pend_pc  <= pend_pc_next;
        end
    end

`ifdef BEXKAT1_IFETCH_COUNT_EN
    // Count every instruction handed to ID; redirects do not clear it.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            fetch_count_o <= 32'h0;
        end else if (load_ir) begin
            fetch_count_o <= fetch_count_o + 32'd1;
        end
    end
`else
    logic unused_load;
    assign unused_load = load_ir;
`endif

endmodule

// File: tb/tb_bexkat1_ifetch.sv
// Directed testbench for bexkat1_ifetch with a scoreboard of expected instructions.
module tb_bexkat1_ifetch;

    logic        clk_i;
    logic        rst_i;
    logic        stall_i;
    logic        pc_set_i;
    logic [31:0] pc_i;
    logic        bus_cyc_o;
    logic        bus_stb_o;
    logic [31:0] bus_adr_o;
    logic [31:0] bus_dat_i;
    logic        bus_ack_i;
    logic [63:0] ir_o;
    logic [31:0] pc_o;

    typedef struct {
        logic [63:0] ir;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    bexkat1_ifetch #(.RESET_VEC(32'h0000_0100)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .stall_i   (stall_i),
        .pc_set_i  (pc_set_i),
        .pc_i      (pc_i),
        .bus_cyc_o (bus_cyc_o),
        .bus_stb_o (bus_stb_o),
        .bus_adr_o (bus_adr_o),
        .bus_dat_i (bus_dat_i),
        .bus_ack_i (bus_ack_i),
        .ir_o      (ir_o),
        .pc_o      (pc_o)
    );

    // Free-running clock.
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Safety net so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not finish, actual=running required=finished");
        $fatal(1, "[TB] timeout");
    end

    // Drive one cycle of inputs, let the clock edge happen, then settle past it.
    task automatic applyStimulus(input logic rst, input logic stall, input logic pc_set,
                                 input logic [31:0] pc, input logic ack, input logic [31:0] dat);
        rst_i     = rst;
        stall_i   = stall;
        pc_set_i  = pc_set;
        pc_i      = pc;
        bus_ack_i = ack;
        bus_dat_i = dat;
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: actual=%h required=%h", tag, obs, exp);
        end
    endtask

    // Pop the next expected instruction and compare it to what ID sees.
    task automatic checkIr(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL %s: actual=ir_o %h required=scoreboard entry", tag, ir_o);
        end else begin
            e = sb.pop_front();
            checkOutput({tag, "_ir"}, ir_o, e.ir);
            checkOutput({tag, "_pc"}, {32'h0, pc_o}, {32'h0, e.pc});
        end
    endtask

    task automatic pushExp(input logic [63:0] ir, input logic [31:0] pc);
        exp_t e;
        e.ir = ir;
        e.pc = pc;
        sb.push_back(e);
    endtask

    // Directed sequence.
    initial begin
        rst_i = 1'b0; stall_i = 1'b0; pc_set_i = 1'b0; pc_i = 32'h0;
        bus_ack_i = 1'b0; bus_dat_i = 32'h0;

        // Reset held for three edges.
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("rst_cyc", {63'h0, bus_cyc_o}, 64'h0);
        checkOutput("rst_ir", ir_o, 64'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("rst_cyc_last", {63'h0, bus_cyc_o}, 64'h0);
        checkOutput("rst_pc", {32'h0, pc_o}, 64'h0);

        // Release: one idle cycle, then fetch from the reset vector.
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("boot_cyc", {63'h0, bus_cyc_o}, 64'h1);
        checkOutput("boot_stb", {63'h0, bus_stb_o}, 64'h1);
        checkOutput("boot_adr", {32'h0, bus_adr_o}, 64'h100);

        // Short instruction.
        pushExp(64'h0000_0000_1000_0000, 32'h100);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1000_0000);
        checkIr("short");
        checkOutput("short_cyc", {63'h0, bus_cyc_o}, 64'h1);
        checkOutput("short_adr", {32'h0, bus_adr_o}, 64'h104);

        // Long instruction.
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h7020_0001);
        checkOutput("long_w1_adr", {32'h0, bus_adr_o}, 64'h108);
        checkOutput("long_bubble", ir_o, 64'h0);
        pushExp(64'hDEAD_BEEF_7020_0001, 32'h104);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
        checkIr("long");
        checkOutput("long_next_adr", {32'h0, bus_adr_o}, 64'h10C);

        // Stall from the cycle of the 0x10C ack for four cycles.
        pushExp(64'h0000_0000_3000_0000, 32'h10C);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h3000_0000);
        checkOutput("stall_hold_ir", ir_o, 64'hDEAD_BEEF_7020_0001);
        checkOutput("stall_cyc", {63'h0, bus_cyc_o}, 64'h0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
            checkOutput("stall_hold_ir_n", ir_o, 64'hDEAD_BEEF_7020_0001);
            checkOutput("stall_cyc_n", {63'h0, bus_cyc_o}, 64'h0);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checkIr("stall_release");
        checkOutput("stall_release_adr", {32'h0, bus_adr_o}, 64'h110);

        // Redirect during a long fetch with a simultaneous ack.
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h5000_0001);
        checkOutput("redir_w1_adr", {32'h0, bus_adr_o}, 64'h114);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h2000, 1'b1, 32'hBAD0_BAD0);
        checkOutput("redir_ir", ir_o, 64'h0);
        checkOutput("redir_cyc", {63'h0, bus_cyc_o}, 64'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("redir_adr", {32'h0, bus_adr_o}, 64'h2000);
        checkOutput("redir_cyc2", {63'h0, bus_cyc_o}, 64'h1);
        checkOutput("redir_ir2", ir_o, 64'h0);

        // Redirect while stalled with an instruction pending.
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h4400_0000);
        checkOutput("pend_cyc", {63'h0, bus_cyc_o}, 64'h0);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h3002, 1'b0, 32'h0);
        checkOutput("pend_redir_ir", ir_o, 64'h0);
        checkOutput("pend_redir_cyc", {63'h0, bus_cyc_o}, 64'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("pend_redir_ir2", ir_o, 64'h0);
        checkOutput("pend_redir_adr", {32'h0, bus_adr_o}, 64'h3000);
        pushExp(64'h0000_0000_6600_0000, 32'h3000);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h6600_0000);
        checkIr("after_discard");

        // Long instruction straddling the top of the address space.
        applyStimulus(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("wrap_w0_adr", {32'h0, bus_adr_o}, 64'hFFFF_FFFC);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1234_5679);
        checkOutput("wrap_w1_adr", {32'h0, bus_adr_o}, 64'h0);
        pushExp(64'hCAFE_F00D_1234_5679, 32'hFFFF_FFFC);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hCAFE_F00D);
        checkIr("wrap_long");
        checkOutput("wrap_next_adr", {32'h0, bus_adr_o}, 64'h4);

        // Reset mid-transfer; a late ack must be ignored.
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("midrst_cyc", {63'h0, bus_cyc_o}, 64'h0);
        checkOutput("midrst_ir", ir_o, 64'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h7777_0000);
        checkOutput("midrst_late_ack_ir", ir_o, 64'h0);
        checkOutput("midrst_adr", {32'h0, bus_adr_o}, 64'h100);
        checkOutput("midrst_cyc2", {63'h0, bus_cyc_o}, 64'h1);

        checkOutput("sb_empty", 64'(sb.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bexkat1_ifetch.md
Name: bexkat1_ifetch

Overview:
- Instruction fetch stage of the bexkat1 pipeline; sits directly upstream of ID and the hazard unit.
- Fetches 32-bit words over a Wishbone-classic instruction port.
- Assembles the 64-bit IR: a long instruction (word0 bit 0 = 1) takes a second immediate word into IR[63:32].
- Presents the IR to ID. Honours the hazard unit's stall and redirects on branch/exception.

Parameters:
- RESET_VEC, 32'h0000_0000, byte address of the first fetch after reset.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-low.
- stall_i  in  1  from hazard stall_o; ID cannot accept a new IR.
- pc_set_i  in  1  redirect request from EXE (branch/jump/exception).
- pc_i  in  32  redirect target byte address.
- bus_cyc_o  out  1  bus cycle.
- bus_stb_o  out  1  bus strobe; always equal to bus_cyc_o.
- bus_adr_o  out  32  word fetch byte address.
- bus_dat_i  in  32  read data.
- bus_ack_i  in  1  read acknowledge.
- ir_o  out  64  instruction to ID; 64'h0 means bubble.
- pc_o  out  32  byte address of word0 of ir_o; 0 when ir_o is a bubble.

Behaviour:
- States:
  - S_IDLE: cyc=0, one-cycle gap.
  - S_W0: fetch word0.
  - S_W1: fetch word1.
  - S_HOLD: complete instruction pending, cyc=0.
- Reset (rst_i=0 at an edge):
  - fetch PC <= RESET_VEC; ir_o, pc_o, pending buffer <= 0; state <= S_IDLE.
  - bus_cyc_o=bus_stb_o=0 in the cycle after the reset edge.
  - Reset mid-transfer abandons the transfer; a later ack is ignored.
- Bus outputs:
  - bus_cyc_o/bus_stb_o high exactly in S_W0/S_W1.
  - bus_adr_o = fetch PC in S_W0, fetch PC+4 in S_W1; held stable until ack.
- S_IDLE -> S_W0 unconditionally.
- S_W0 with ack:
  - Latch bus_dat_i as word0.
  - bus_dat_i[0]=1: go to S_W1.
  - Otherwise the instruction completes with IR={32'h0, word0} and fetch PC += 4.
- S_W1 with ack: the instruction completes with IR={bus_dat_i, word0} and fetch PC += 8.
- Completion with stall_i=0:
  - ir_o <= IR, pc_o <= instruction address; return to S_W0 (back-to-back, no gap).
- Completion with stall_i=1:
  - IR and its address go to the pending buffer; ir_o/pc_o unchanged; state <= S_HOLD.
- S_HOLD:
  - stall_i=1: hold.
  - stall_i=0: ir_o/pc_o <= pending; state <= S_W0.
- Any cycle with stall_i=0 and no completion/hold-release: ir_o <= 0, pc_o <= 0 (bubble).
- Any cycle with stall_i=1: ir_o/pc_o hold their value.
- Redirect (pc_set_i=1) has priority over stall_i, completion and ack:
  - fetch PC <= pc_i; ir_o, pc_o, pending <= 0; state <= S_IDLE.
  - An ack in the same cycle is discarded.
- Latency with zero-wait ack (ack in the first stb cycle):
  - short instruction visible on ir_o one cycle after the ack;
  - throughput 1 short instruction/cycle, 1 long instruction per 2 cycles.
- Addresses are 32-bit and wrap modulo 2^32; no alignment check; pc_i[1:0] is forced to 0.

Optional Feature:
- Macro: BEXKAT1_IFETCH_COUNT_EN.
- Defined:
  - adds output port fetch_count_o [31:0];
  - increments by 1 each time a non-bubble IR is written to ir_o;
  - reset to 0; wraps at 2^32; not cleared by pc_set_i.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset: RESET_VEC=32'h100; hold rst_i=0 for 3 cycles, then release.
  - During reset: bus_cyc_o=0, ir_o=0.
  - bus_cyc_o=1 with bus_adr_o=32'h100 on the 2nd cycle after release.
- Short instruction: ack at 0x100 with 32'h1000_0000.
  - Next cycle: ir_o=64'h0000_0000_1000_0000, pc_o=32'h100.
  - bus_adr_o=32'h104 with no cyc gap.
- Long instruction: word0 32'h7020_0001 at 0x104, then word1 32'hDEAD_BEEF at 0x108.
  - ir_o=64'hDEAD_BEEF_7020_0001, pc_o=32'h104.
  - Next bus_adr_o=32'h10C.
- Stall: stall_i=1 from the cycle of the 0x10C ack for 4 cycles.
  - ir_o holds the previous IR; bus_cyc_o=0 while stalled.
  - One cycle after stall_i falls, ir_o shows the 0x10C instruction.
- Redirect mid long fetch: pc_set_i=1, pc_i=32'h2000 while in S_W1, with a simultaneous ack.
  - Next cycle: ir_o=0, bus_cyc_o=0.
  - Following cycle: bus_adr_o=32'h2000; the acked word never appears on ir_o.
- Redirect vs stall: pc_set_i=1 and stall_i=1 in the same cycle with an instruction pending in S_HOLD.
  - Pending is discarded; ir_o=0; fetch resumes at pc_i.
  - With BEXKAT1_IFETCH_COUNT_EN, fetch_count_o is unchanged by the discarded instruction.
